mc_ctrl_fsm: RTL
================

Name: mc_ctrl_fsm

Overview:
Multi-cycle control sequencer for the RV32I core. It replaces single-cycle main decoding when the datapath shares one memory port and one ALU across cycles. It steps through fetch, decode, execute, memory and writeback states, and drives the datapath mux selects and write enables. It handles a memory ready handshake and qualifies branches with the ALU zero flag.

Parameters:
RESET_STATE, 4'd0, state entered on reset (FETCH); changed only for bring-up benches.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
opcode  input  7  instr[6:0] from the instruction register, valid from DECODE onward
zero  input  1  ALU zero flag
mem_ready  input  1  shared memory port has completed the current access
pc_write  output  1  PC register load enable
adr_src  output  1  memory address select: 0 = PC, 1 = ALU result register
ir_write  output  1  instruction register and old-PC register load enable
mem_write  output  1  memory write strobe
reg_write  output  1  register file write enable
result_src  output  2  result select: 00 = ALU out register, 01 = read data, 10 = ALU result
alu_src_a  output  2  ALU A select: 00 = PC, 01 = old PC, 10 = rs1
alu_src_b  output  2  ALU B select: 00 = rs2, 01 = immediate, 10 = constant 4
alu_op  output  2  00 = add, 01 = subtract (branch), 10 = decode funct3/funct7
imm_src  output  2  immediate format, decoded combinationally from opcode: lw/I-type 00, sw 01, beq 10, jal 11, otherwise 00
illegal_instr  output  1  one-cycle pulse in DECODE when the opcode is unsupported
state_o  output  4  current state, for debug and the bench

Behaviour:
- State register is 4 bits. Encoding: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, ALUWB 7, EXECUTEI 8, JAL 9, BEQ 10. Codes 11–15 are unreachable and return to FETCH on the next edge.
- Reset: sampled on the clk edge; state <= FETCH. While reset is high, all outputs are 0 and state_o = 0. Reset asserted mid-instruction abandons it; no write enable fires in that cycle.
- Outputs are Moore-decoded from state, except pc_write, ir_write and mem_write, which are also qualified by inputs as listed below.
- Unlisted outputs are 0 in every state.
- FETCH:
  - Drives adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
  - ir_write = pc_write = mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - Drives alu_src_a=01, alu_src_b=01, alu_op=00 (branch target precompute).
  - Next state by opcode: 0000011/0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1101111 -> JAL; 1100011 -> BEQ.
  - Any other opcode: illegal_instr=1, next state FETCH.
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. Goes to MEMREAD if opcode[5]=0, otherwise MEMWRITE.
- MEMREAD: adr_src=1, result_src=00. Waits for mem_ready, then goes to MEMWB.
- MEMWB: result_src=01, reg_write=1. Goes to FETCH.
- MEMWRITE:
  - Drives adr_src=1, result_src=00, mem_write=1.
  - mem_write holds until mem_ready=1, then the state goes to FETCH.
  - mem_write is never asserted outside MEMWRITE.
- EXECUTER: alu_src_a=10, alu_src_b=00, alu_op=10. Goes to ALUWB.
- EXECUTEI: alu_src_a=10, alu_src_b=01, alu_op=10. Goes to ALUWB.
- ALUWB: result_src=00, reg_write=1. Goes to FETCH.
- JAL:
  - Drives alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1.
  - Goes to ALUWB, which writes the link address PC+4.
- BEQ:
  - Drives alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00.
  - pc_write = zero. Goes to FETCH.
- Latency with mem_ready tied to 1: beq 3 cycles; R/I-type, jal and sw 4 cycles; lw 5 cycles. Each wait cycle on mem_ready adds one cycle.

Optional Feature:
MC_PERF_CNT_EN
- Defined:
  - Adds outputs cycle_cnt[31:0] and instret_cnt[31:0], both cleared by reset.
  - cycle_cnt increments every non-reset cycle.
  - instret_cnt increments on every transition into FETCH from a non-FETCH state, except from DECODE when illegal_instr=1.
  - Both counters wrap modulo 2^32.
- Undefined: the ports and counters do not exist. All other behaviour is identical.

Test Plan:
1. Reset held 3 cycles with mem_ready=1, then released -> state_o=0, all enables 0 during reset; cycle 1 after release ir_write=1, pc_write=1; then state_o=1.
2. mem_ready=1, opcode 0000011 (lw) -> state sequence 0,1,2,3,4,0; reg_write=1 only in state 4, with result_src=01.
3. opcode 0100011 (sw), mem_ready low for 2 cycles in MEMWRITE -> mem_write=1 for 3 consecutive cycles, then FETCH; reg_write stays 0 throughout.
4. opcode 1100011 (beq): with zero=1, pc_write=1 in state 10; with zero=0, pc_write=0; both cases return to FETCH after 3 cycles.
5. opcode 1101111 (jal) -> states 0,1,9,7,0; pc_write=1 in 9; reg_write=1 in 7; imm_src=11.
6. opcode 0110111 (unsupported) -> illegal_instr=1 for one cycle in DECODE, then FETCH. With MC_PERF_CNT_EN: instret_cnt unchanged for the illegal opcode, +1 after a following add.

Source files
------------

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle RV32I control sequencer: drives shared-memory/ALU datapath selects and enables.
// Optional MC_PERF_CNT_EN adds cycle_cnt / instret_cnt performance counters.
module mc_ctrl_fsm #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] imm_src,
  output logic       illegal_instr,
  output logic [3:0] state_o
`ifdef MC_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    ALUWB    = 4'd7,
    EXECUTEI = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  state_t state;
  state_t next_state;
  logic   legal_op;

  always_comb begin
    case (opcode)
      OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_JAL, OP_BEQ: legal_op = 1'b1;
      default:                                               legal_op = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= state_t'(RESET_STATE);
    else       state <= next_state;
  end

  // Unused encodings 11-15 fall through to the default and recover to FETCH.
  always_comb begin
    next_state = FETCH;
    case (state)
      FETCH:    next_state = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: next_state = MEMADR;
          OP_RTYPE:          next_state = EXECUTER;
          OP_ITYPE:          next_state = EXECUTEI;
          OP_JAL:            next_state = JAL;
          OP_BEQ:            next_state = BEQ;
          default:           next_state = FETCH;
        endcase
      end
      MEMADR:   next_state = opcode[5] ? MEMWRITE : MEMREAD;
      MEMREAD:  next_state = mem_ready ? MEMWB : MEMREAD;
      MEMWB:    next_state = FETCH;
      MEMWRITE: next_state = mem_ready ? FETCH : MEMWRITE;
      EXECUTER: next_state = ALUWB;
      EXECUTEI: next_state = ALUWB;
      ALUWB:    next_state = FETCH;
      JAL:      next_state = ALUWB;
      BEQ:      next_state = FETCH;
      default:  next_state = FETCH;
    endcase
  end

  // Everything is forced low while reset is high so an abandoned instruction cannot write.
  always_comb begin
    pc_write      = 1'b0;
    adr_src       = 1'b0;
    ir_write      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    result_src    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    imm_src       = 2'b00;
    illegal_instr = 1'b0;
    if (!reset) begin
      case (opcode)
        OP_STORE: imm_src = 2'b01;
        OP_BEQ:   imm_src = 2'b10;
        OP_JAL:   imm_src = 2'b11;
        default:  imm_src = 2'b00;
      endcase
      case (state)
        FETCH: begin
          alu_src_b  = 2'b10;
          result_src = 2'b10;
          ir_write   = mem_ready;
          pc_write   = mem_ready;
        end
        DECODE: begin
          alu_src_a     = 2'b01;
          alu_src_b     = 2'b01;
          illegal_instr = ~legal_op;
        end
        MEMADR: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
        end
        MEMREAD:  adr_src = 1'b1;
        MEMWB: begin
          result_src = 2'b01;
          reg_write  = 1'b1;
        end
        MEMWRITE: begin
          adr_src   = 1'b1;
          mem_write = 1'b1;
        end
        EXECUTER: begin
          alu_src_a = 2'b10;
          alu_op    = 2'b10;
        end
        EXECUTEI: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
          alu_op    = 2'b10;
        end
        ALUWB:    reg_write = 1'b1;
        JAL: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
          pc_write  = 1'b1;
        end
        BEQ: begin
          alu_src_a = 2'b10;
          alu_op    = 2'b01;
          pc_write  = zero;
        end
        default: ;
      endcase
    end
  end

  assign state_o = reset ? 4'd0 : state;

`ifdef MC_PERF_CNT_EN
  logic retire;

  // An instruction retires on any return to FETCH except the illegal-opcode bailout from DECODE.
  assign retire = (state != FETCH) && (next_state == FETCH) &&
                  !((state == DECODE) && !legal_op);

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt   <= 32'd0;
      instret_cnt <= 32'd0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (retire) instret_cnt <= instret_cnt + 32'd1;
    end
  end
`endif

endmodule
